// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem request handshake, IF/ID register with one-entry hold buffer
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        IF_ID_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_inst,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP, HALTED} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        req_en;
    logic        accept;

    always_comb begin
        // req_en keeps the request low until the first edge after reset release
        imem_req   = req_en && (state == FETCH || state == DROP);
        imem_addr  = (state == DROP) ? drop_addr : pc;
        accept     = (state == FETCH) && imem_req && imem_ready;
        fetch_busy = (state == FETCH || state == DROP) && imem_req && !imem_ready;
        next_state = state;
        case (state)
            FETCH:   if (accept && !IF_ID_write) next_state = HOLD;
            HOLD:    if (IF_ID_write) next_state = FETCH;
            DROP:    if (imem_ready) next_state = FETCH;
            default: next_state = HALTED;
        endcase
        if (redirect_valid && state != HALTED)
            next_state = (imem_req && !imem_ready) ? DROP : FETCH;
        if (halt)
            next_state = HALTED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            drop_addr   <= 32'h0;
            buf_inst    <= NOP_INST;
            buf_pc      <= 32'h0;
            req_en      <= 1'b0;
            IF_ID_inst  <= NOP_INST;
            IF_ID_pc    <= 32'h0;
            IF_ID_valid <= 1'b0;
        end else begin
            req_en <= 1'b1;
            if (halt) begin
                if (state != HALTED) begin
                    IF_ID_valid <= 1'b0;
                    IF_ID_inst  <= NOP_INST;
                end
            end else if (state == HALTED) begin
                // frozen until reset
            end else if (redirect_valid) begin
                // DROP keeps the address of the request still in flight
                if (state == FETCH)
                    drop_addr <= pc;
                pc          <= redirect_pc & 32'hFFFF_FFFC;
                IF_ID_valid <= 1'b0;
                IF_ID_inst  <= NOP_INST;
            end else begin
                case (state)
                    FETCH: begin
                        if (accept) begin
                            if (PC_write)
                                pc <= pc + 32'd4;
                            if (IF_ID_write) begin
                                IF_ID_inst  <= imem_rdata;
                                IF_ID_pc    <= pc;
                                IF_ID_valid <= 1'b1;
                            end else begin
                                buf_inst <= imem_rdata;
                                buf_pc   <= pc;
                            end
                        end else if (IF_ID_write) begin
                            IF_ID_inst  <= NOP_INST;
                            IF_ID_pc    <= pc;
                            IF_ID_valid <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (IF_ID_write) begin
                            IF_ID_inst  <= buf_inst;
                            IF_ID_pc    <= buf_pc;
                            IF_ID_valid <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
